// File: rtl/board_io_ctrl.sv
// Board I/O controller: memory-mapped LEDs, debounced keys with press/release
// events and interrupt, hex seven-segment digits and 8-bit RGB PWM.
// Ports: clk/rst_n; rd_*/wr_* zero-wait-state bus (rd_data one cycle after
// request); key_in raw active-low buttons; led, seg, rgb drives; irq level.
module board_io_ctrl #(
  parameter int N_KEY      = 2,
  parameter int N_LED      = 8,
  parameter int N_DIGIT    = 2,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  output logic                 rd_gnt,
  input  logic [31:0]          rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 wr_req,
  output logic                 wr_gnt,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [N_KEY-1:0]     key_in,
  output logic [N_LED-1:0]     led,
  output logic [8*N_DIGIT-1:0] seg,
  output logic [2:0]           rgb,
  output logic                 irq
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // Bus registers
  logic [N_LED-1:0]     led_q, led_d;
  logic [N_KEY-1:0]     press_q, press_d;      // press events
  logic [N_KEY-1:0]     rel_q, rel_d;          // release events
  logic [N_KEY-1:0]     en_press_q, en_press_d;
  logic [N_KEY-1:0]     en_rel_q, en_rel_d;
  logic [4*N_DIGIT-1:0] nib_q, nib_d;
  logic [N_DIGIT-1:0]   dp_q, dp_d;
  logic [23:0]          duty_q, duty_d;        // {b,g,r}
  logic [31:0]          rd_data_q, rd_data_d;
  logic [31:0]          rd_mux;
  logic                 irq_q, irq_d;

  // Key path
  logic [N_KEY-1:0]          sync1_q, sync2_q;
  logic [N_KEY-1:0]          acc_q, acc_d;     // accepted level, 1 = pressed
  logic [N_KEY-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_KEY-1:0]          sync_pressed;
  logic [N_KEY-1:0]          key_rise, key_fall;

  // PWM
  logic [7:0] pwm_q, pwm_d;
  logic [2:0] rgb_q, rgb_d;

  logic unused_ok;
  assign unused_ok = ^{rd_addr[31:5], rd_addr[1:0], wr_addr[31:5], wr_addr[1:0], wr_data};

  assign rd_gnt  = rd_req;
  assign wr_gnt  = wr_req;
  assign rd_data = rd_data_q;
  assign led     = led_q;
  assign rgb     = rgb_q;
  assign irq     = irq_q;

  // Keys are active-low on the pins; everything downstream is 1 = pressed.
  assign sync_pressed = ~sync2_q;

  // Debounce: the counter runs only while the synchronised level disagrees
  // with the accepted level, so a bounce back to the accepted level restarts
  // the qualification window from zero.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int k = 0; k < N_KEY; k++) begin
      if (sync_pressed[k] != acc_q[k]) begin
        if (cnt_q[k] == DEB_LAST) begin
          acc_d[k] = ~acc_q[k];
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  assign key_rise = acc_d & ~acc_q;
  assign key_fall = ~acc_d & acc_q;

  // Register writes; new key events are OR-ed in after the W1C clear so a
  // coincident event survives the clear.
  always_comb begin
    led_d      = led_q;
    press_d    = press_q;
    rel_d      = rel_q;
    en_press_d = en_press_q;
    en_rel_d   = en_rel_q;
    nib_d      = nib_q;
    dp_d       = dp_q;
    duty_d     = duty_q;
    if (wr_req) begin
      case (wr_addr[4:2])
        3'd0: led_d = wr_data[N_LED-1:0];
        3'd2: begin
          press_d = press_q & ~wr_data[N_KEY-1:0];
          rel_d   = rel_q & ~wr_data[N_KEY+7:8];
        end
        3'd3: begin
          en_press_d = wr_data[N_KEY-1:0];
          en_rel_d   = wr_data[N_KEY+7:8];
        end
        3'd4: begin
          nib_d = wr_data[4*N_DIGIT-1:0];
          dp_d  = wr_data[16+N_DIGIT-1:16];
        end
        3'd5: duty_d = wr_data[23:0];
        default: ;
      endcase
    end
    press_d = press_d | key_rise;
    rel_d   = rel_d | key_fall;
  end

  // Read mux sees pre-edge register values, so a same-cycle write is not
  // visible to the read.
  always_comb begin
    rd_mux = '0;
    case (rd_addr[4:2])
      3'd0: rd_mux[N_LED-1:0] = led_q;
      3'd1: rd_mux[N_KEY-1:0] = acc_q;
      3'd2: begin
        rd_mux[N_KEY-1:0]  = press_q;
        rd_mux[N_KEY+7:8]  = rel_q;
      end
      3'd3: begin
        rd_mux[N_KEY-1:0]  = en_press_q;
        rd_mux[N_KEY+7:8]  = en_rel_q;
      end
      3'd4: begin
        rd_mux[4*N_DIGIT-1:0]     = nib_q;
        rd_mux[16+N_DIGIT-1:16]   = dp_q;
      end
      3'd5: rd_mux[23:0] = duty_q;
      default: ;
    endcase
  end

  assign rd_data_d = rd_req ? rd_mux : rd_data_q;
  assign irq_d     = (|(press_q & en_press_q)) | (|(rel_q & en_rel_q));

  // Period of 255: duty 255 is then always above the counter.
  assign pwm_d = (pwm_q == 8'd254) ? 8'd0 : pwm_q + 8'd1;
  assign rgb_d = {pwm_q < duty_q[23:16], pwm_q < duty_q[15:8], pwm_q < duty_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      en_press_q <= '0;
      en_rel_q   <= '0;
      nib_q      <= '0;
      dp_q       <= '0;
      duty_q     <= '0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_q      <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      rgb_q      <= '0;
    end else begin
      led_q      <= led_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      en_press_q <= en_press_d;
      en_rel_q   <= en_rel_d;
      nib_q      <= nib_d;
      dp_q       <= dp_d;
      duty_q     <= duty_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      rgb_q      <= rgb_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    seg = '0;
    for (int d = 0; d < N_DIGIT; d++) begin
      seg[8*d +: 8] = {dp_q[d], hex7(nib_q[4*d +: 4])};
    end
  end

endmodule
